keypad_scan_entry: RTL and testbench

- Upstream input stage for the serial password lock.
- Scans a 4x4 hex matrix keypad, synchronises and debounces the row returns, and encodes each key press as a 4-bit digit.
- Emits exactly one single-cycle strobe per physical press, so the lock consumes one digit per press.
- Also flags ambiguous multi-key presses.

---
 rtl/keypad_scan_entry.sv | 140 ++++++++++++++
 tb/tb_keypad_scan_entry.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_entry.sv
// rtl/keypad_scan_entry.sv - 4x4 keypad scanner with row synchroniser, press/release debounce and one strobe per press.
module keypad_scan_entry #(
  parameter int SCAN_DIV        = 4,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] digit,
  output logic       digitStrobe,
  output logic       keyHeld,
  output logic       multiKeyError
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_PRESSED} state_t;

  state_t        state_q;
  logic [3:0]    rows_meta_q, rows_sync_q;
  logic [SW-1:0] scan_cnt_q;
  logic [DW-1:0] deb_cnt_q;
  logic [3:0]    cols_q;
  logic [3:0]    code_q;
  logic [3:0]    pattern_q;
  logic [3:0]    digit_q;
  logic          strobe_q, held_q, err_q;

  logic [1:0]    row_idx, col_idx;
  logic          one_low, all_high;
  logic [3:0]    cols_next;

  always_comb begin
    row_idx = 2'd0;
    one_low = 1'b0;
    case (rows_sync_q)
      4'b1110: begin row_idx = 2'd0; one_low = 1'b1; end
      4'b1101: begin row_idx = 2'd1; one_low = 1'b1; end
      4'b1011: begin row_idx = 2'd2; one_low = 1'b1; end
      4'b0111: begin row_idx = 2'd3; one_low = 1'b1; end
      default: begin row_idx = 2'd0; one_low = 1'b0; end
    endcase
    col_idx = 2'd0;
    case (cols_q)
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
    all_high  = (rows_sync_q == 4'hF);
    cols_next = {cols_q[2:0], cols_q[3]};
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_SCAN;
      rows_meta_q <= 4'hF;
      rows_sync_q <= 4'hF;
      scan_cnt_q  <= '0;
      deb_cnt_q   <= '0;
      cols_q      <= 4'b1110;
      code_q      <= 4'd0;
      pattern_q   <= 4'hF;
      digit_q     <= 4'd0;
      strobe_q    <= 1'b0;
      held_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      rows_meta_q <= rows;
      rows_sync_q <= rows_meta_q;
      strobe_q    <= 1'b0;
      err_q       <= 1'b0;
      case (state_q)
        S_SCAN: begin
          if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_q <= '0;
            if (all_high) begin
              cols_q <= cols_next;
            end else if (one_low) begin
              code_q    <= {row_idx, col_idx};
              pattern_q <= rows_sync_q;
              deb_cnt_q <= '0;
              state_q   <= S_DEBOUNCE;
            end else begin
              err_q  <= 1'b1;
              cols_q <= cols_next;
            end
          end else begin
            scan_cnt_q <= scan_cnt_q + 1'b1;
          end
        end
        S_DEBOUNCE: begin
          if (rows_sync_q == pattern_q) begin
            if (deb_cnt_q == DEB_LAST) begin
              state_q   <= S_PRESSED;
              digit_q   <= code_q;
              strobe_q  <= 1'b1;
              held_q    <= 1'b1;
              deb_cnt_q <= '0;
            end else begin
              deb_cnt_q <= deb_cnt_q + 1'b1;
            end
          end else begin
            state_q    <= S_SCAN;
            scan_cnt_q <= '0;
            cols_q     <= cols_next;
          end
        end
        S_PRESSED: begin
          // Any low row, including a second key, restarts the release count.
          if (all_high) begin
            if (deb_cnt_q == DEB_LAST) begin
              held_q     <= 1'b0;
              state_q    <= S_SCAN;
              scan_cnt_q <= '0;
              deb_cnt_q  <= '0;
              cols_q     <= cols_next;
            end else begin
              deb_cnt_q <= deb_cnt_q + 1'b1;
            end
          end else begin
            deb_cnt_q <= '0;
          end
        end
        default: state_q <= S_SCAN;
      endcase
    end
  end

  assign cols          = cols_q;
  assign digit         = digit_q;
  assign digitStrobe   = strobe_q;
  assign keyHeld       = held_q;
  assign multiKeyError = err_q;

endmodule

// File: tb/tb_keypad_scan_entry.sv
// tb/tb_keypad_scan_entry.sv - randomized keypad press bench against an event-level press/strobe model.
module tb_keypad_scan_entry;
  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;
  localparam int LAT_MAX  = 2 + (SCAN_DIV - 1) + DEB + 3 * SCAN_DIV + 1;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [3:0] rows, cols, digit;
  logic       digitStrobe, keyHeld, multiKeyError;
  logic [15:0] key_mask = 16'h0;

  int checks = 0, failures = 0, cyc = 0;
  int got_q[$];
  int exp_q[$];
  int err_cnt = 0, last_strobe_cyc = -1;
  int onehot_bad = 0, both_bad = 0, digit_bad = 0, rot_bad = 0, advances = 0;
  int exp_digit = 0;
  logic [3:0] prev_cols = 4'b1110, prev_digit = 4'd0;

  keypad_scan_entry #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
    .CLK(CLK), .RST(RST), .rows(rows), .cols(cols), .digit(digit),
    .digitStrobe(digitStrobe), .keyHeld(keyHeld), .multiKeyError(multiKeyError)
  );

  always #5 CLK = ~CLK;

  // Physical keypad: key k = row*4+col pulls its row low while its column is driven.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (key_mask[r*4+c] && !cols[c]) rows[r] = 1'b0;
  end

  always @(posedge CLK) cyc++;

  always @(negedge CLK) begin
    if (RST) begin
      if (digitStrobe) begin
        got_q.push_back(int'(digit));
        last_strobe_cyc = cyc;
      end
      if (multiKeyError) err_cnt++;
      if (digitStrobe && multiKeyError) both_bad++;
      if (!(cols inside {4'b1110, 4'b1101, 4'b1011, 4'b0111})) onehot_bad++;
      if (digit !== prev_digit && !digitStrobe) digit_bad++;
      if (cols !== prev_cols) begin
        advances++;
        if (cols !== {prev_cols[2:0], prev_cols[3]}) rot_bad++;
      end
    end
    prev_cols  = cols;
    prev_digit = digit;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_cols"}, int'(cols), 14);
    check_eq({tag, "_digit"}, int'(digit), 0);
    check_eq({tag, "_strobe"}, int'(digitStrobe), 0);
    check_eq({tag, "_held"}, int'(keyHeld), 0);
    check_eq({tag, "_err"}, int'(multiKeyError), 0);
  endtask

  task automatic compare_queues(input string tag);
    check_eq({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check_eq($sformatf("%s_digit%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  initial begin
    int start, adv0, k, k2, hold, rel;
    tick(2);
    check_reset_vals("rst");
    RST = 1'b1;
    tick(20);

    // Stable key 9 (row 2, col 1) for 100 cycles
    got_q.delete();
    start = cyc;
    key_mask = 16'd1 << 9;
    tick(100);
    exp_q = '{9};
    compare_queues("hold9");
    check_eq("hold9_latency_ok", int'((last_strobe_cyc - start) <= LAT_MAX && last_strobe_cyc >= start), 1);
    check_eq("hold9_held", int'(keyHeld), 1);
    key_mask = 16'h0;
    tick(DEB + 1);
    check_eq("hold9_held_before_release", int'(keyHeld), 1);
    tick(1);
    check_eq("hold9_released", int'(keyHeld), 0);
    exp_digit = 9;
    tick(30);

    // Bounce on key 3 (row 0, col 3): low 5, high 3, then stable
    got_q.delete();
    key_mask = 16'd1 << 3;
    tick(5);
    key_mask = 16'h0;
    tick(3);
    check_eq("bounce_no_strobe", got_q.size(), 0);
    key_mask = 16'd1 << 3;
    tick(60);
    exp_q = '{3};
    compare_queues("bounce");
    key_mask = 16'h0;
    exp_digit = 3;
    tick(30);

    // Lone 5-cycle glitches at several scan phases
    for (int i = 0; i < 4; i++) begin
      got_q.delete();
      tick(1 + i * 3);
      key_mask = 16'd1 << 3;
      tick(5);
      key_mask = 16'h0;
      tick(40);
      check_eq($sformatf("glitch%0d_no_strobe", i), got_q.size(), 0);
    end

    // Rows 1 and 3 together on col 0
    got_q.delete();
    err_cnt = 0;
    key_mask = (16'd1 << 4) | (16'd1 << 12);
    tick(64);
    key_mask = 16'h0;
    tick(20);
    check_eq("multi_no_strobe", got_q.size(), 0);
    check_eq("multi_digit_kept", int'(digit), exp_digit);
    check_eq("multi_err_in_range", int'(err_cnt >= 3 && err_cnt <= 5), 1);

    // Sequence 0,1,2,9
    got_q.delete();
    exp_q = '{0, 1, 2, 9};
    foreach (exp_q[i]) begin
      key_mask = 16'd1 << exp_q[i];
      tick(40);
      key_mask = 16'h0;
      tick(40);
    end
    compare_queues("seq");
    exp_digit = 9;

    // Reset while key 5 is held and accepted
    key_mask = 16'd1 << 5;
    tick(40);
    check_eq("rst5_held_before", int'(keyHeld), 1);
    got_q.delete();
    RST = 1'b0;
    #1;
    check_reset_vals("rst5_async");
    tick(3);
    check_reset_vals("rst5_during");
    RST = 1'b1;
    tick(LAT_MAX + 20);
    exp_q = '{5};
    compare_queues("rst5");
    key_mask = 16'h0;
    exp_digit = 5;
    tick(30);

    // Idle scan rotation
    got_q.delete();
    err_cnt = 0;
    adv0 = advances;
    tick(64);
    check_eq("idle_advances", advances - adv0, 64 / SCAN_DIV);
    check_eq("idle_no_strobe", got_q.size(), 0);
    check_eq("idle_no_err", err_cnt, 0);

    // Randomized presses, some with a pre-bounce or an ignored second key
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < 14; i++) begin
      k    = int'($urandom_range(0, 15));
      hold = int'($urandom_range(LAT_MAX + 8, 70));
      rel  = int'($urandom_range(DEB + 6, 40));
      if ($urandom_range(0, 1) == 1) begin
        key_mask = 16'd1 << k;
        tick(int'($urandom_range(1, 5)));
        key_mask = 16'h0;
        tick(3);
      end
      key_mask = 16'd1 << k;
      exp_q.push_back(k);
      tick(LAT_MAX + 4);
      if ($urandom_range(0, 3) == 0) begin
        k2 = int'($urandom_range(0, 15));
        key_mask = key_mask | (16'd1 << k2);
      end
      tick(hold - LAT_MAX - 4);
      key_mask = 16'h0;
      tick(rel);
    end
    compare_queues("rand");
    if (exp_q.size() > 0) check_eq("rand_final_digit", int'(digit), exp_q[exp_q.size()-1]);

    check_eq("inv_cols_one_low", onehot_bad, 0);
    check_eq("inv_strobe_err_exclusive", both_bad, 0);
    check_eq("inv_digit_changes_on_strobe", digit_bad, 0);
    check_eq("inv_cols_rotation", rot_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
